// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encoding and fetch constants for the memory port arbiter
package mem_port_arbiter_pkg;

    localparam int IBYTES = 4;
    localparam int KW     = $clog2(IBYTES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_MEM  = 3'd1,
        I_MEM  = 3'd2,
        D_RESP = 3'd3,
        I_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/mem_port_arbiter_ifetch_assembler.sv
// rtl/mem_port_arbiter_ifetch_assembler.sv - fetch byte counter, address offset and instruction byte-lane assembly
module ifetch_assembler
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic                  i_advance,
    input  logic [ADDR_W-1:0]     i_base,
    input  logic [7:0]            i_rdata,
    output logic [ADDR_W-1:0]     o_addr,
    output logic                  o_last,
    output logic [8*IBYTES-1:0]   o_word
);

    logic [ADDR_W-1:0]   r_base;
    logic [KW-1:0]       r_k;
    logic [8*IBYTES-1:0] r_word;

    // i_clear is the block's reset; the word is not cleared on load, each lane is overwritten in turn
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_base <= '0;
            r_k    <= '0;
            r_word <= '0;
        end else if (i_load) begin
            r_base <= i_base;
            r_k    <= '0;
        end else if (i_advance) begin
            r_word[8*r_k +: 8] <= i_rdata;
            r_k                <= r_k + 1'b1;
        end
    end

    assign o_addr = r_base + ADDR_W'(r_k);
    assign o_last = (r_k == KW'(IBYTES - 1));
    assign o_word = r_word;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one byte-wide memory between instruction-fetch and load/store ports
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IREAD,
    input  logic [ADDR_W-1:0] IADDRESS,
    output logic [31:0]       IREADDATA,
    output logic              IBUSYWAIT,
    input  logic              DREAD,
    input  logic              DWRITE,
    input  logic [ADDR_W-1:0] DADDRESS,
    input  logic [7:0]        DWRITEDATA,
    output logic [7:0]        DREADDATA,
    output logic              DBUSYWAIT,
    output logic              MREAD,
    output logic              MWRITE,
    output logic [ADDR_W-1:0] MADDRESS,
    output logic [7:0]        MWRITEDATA,
    input  logic [7:0]        MREADDATA,
    input  logic              MBUSYWAIT
);

    state_t            r_state;
    state_t            w_next;
    logic              r_dwrite;
    logic [ADDR_W-1:0] r_daddr;
    logic [7:0]        r_wdata;
    logic [7:0]        r_rdata;

    logic              w_dreq;
    logic              w_done;
    logic              w_fetch_load;
    logic              w_fetch_adv;
    logic              w_last;
    logic [ADDR_W-1:0] w_faddr;
    logic [31:0]       w_word;

    assign w_dreq       = DREAD | DWRITE;
    assign w_done       = ((r_state == D_MEM) || (r_state == I_MEM)) && !MBUSYWAIT;
    assign w_fetch_load = (r_state == IDLE) && !w_dreq && IREAD;
    assign w_fetch_adv  = (r_state == I_MEM) && !MBUSYWAIT;

    ifetch_assembler #(
        .ADDR_W (ADDR_W)
    ) u_ifetch (
        .clk       (CLK),
        .i_clear   (!RESET),
        .i_load    (w_fetch_load),
        .i_advance (w_fetch_adv),
        .i_base    (IADDRESS),
        .i_rdata   (MREADDATA),
        .o_addr    (w_faddr),
        .o_last    (w_last),
        .o_word    (w_word)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state  <= IDLE;
            r_dwrite <= 1'b0;
            r_daddr  <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && w_dreq) begin
                r_daddr  <= DADDRESS;
                r_wdata  <= DWRITEDATA;
                r_dwrite <= DWRITE;
            end
            if ((r_state == D_MEM) && w_done && !r_dwrite) begin
                r_rdata <= MREADDATA;
            end
        end
    end

    // Strobes are decoded from state so a reset edge drops them immediately
    always_comb begin
        w_next = r_state;
        MREAD  = 1'b0;
        MWRITE = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dreq) begin
                    w_next = D_MEM;
                end else if (IREAD) begin
                    w_next = I_MEM;
                end
            end
            D_MEM: begin
                MREAD  = !r_dwrite;
                MWRITE = r_dwrite;
                if (w_done) begin
                    w_next = D_RESP;
                end
            end
            I_MEM: begin
                MREAD = 1'b1;
                if (w_done && w_last) begin
                    w_next = I_RESP;
                end
            end
            D_RESP:  w_next = IDLE;
            I_RESP:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign MADDRESS   = (r_state == I_MEM) ? w_faddr : r_daddr;
    assign MWRITEDATA = r_wdata;
    assign DREADDATA  = r_rdata;
    assign IREADDATA  = w_word;

    assign DBUSYWAIT = RESET && w_dreq && (r_state != D_RESP);
    assign IBUSYWAIT = RESET && IREAD && (r_state != I_RESP);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one byte-wide data memory between the CPU's instruction-fetch port and its data-access port (load/store) using busywait handshakes. Data requests are single byte transfers. Instruction fetches are sequenced as IBYTES consecutive byte reads and assembled into one 32-bit INSTRUCTION word. The block sits between the cpu (PC/INSTRUCTION path and load/store path) and the single memory model, and stalls each requester through its busywait output.

Parameters:
ADDR_W, 8, memory byte-address width; all addresses are taken modulo 2^ADDR_W.
IBYTES, 4, bytes per instruction word; fixed at 4 for a 32-bit INSTRUCTION.

Ports:
CLK  input  1  system clock; all state changes on posedge.
RESET  input  1  synchronous, active-low reset, sampled on posedge CLK.
IREAD  input  1  instruction-fetch request; held high until IBUSYWAIT is seen low.
IADDRESS  input  ADDR_W  byte address of the instruction (PC low bits).
IREADDATA  output  32  assembled instruction; valid while IBUSYWAIT is low in I_RESP.
IBUSYWAIT  output  1  stall for the fetch port.
DREAD  input  1  data read request.
DWRITE  input  1  data write request.
DADDRESS  input  ADDR_W  data byte address.
DWRITEDATA  input  8  store data.
DREADDATA  output  8  load data; valid in D_RESP.
DBUSYWAIT  output  1  stall for the data port.
MREAD  output  1  memory read strobe.
MWRITE  output  1  memory write strobe.
MADDRESS  output  ADDR_W  memory address.
MWRITEDATA  output  8  memory write data.
MREADDATA  input  8  memory read data.
MBUSYWAIT  input  1  memory busy; a transfer completes on a posedge where the strobe is high and MBUSYWAIT is low.

Behaviour:
- Single clock. Reset is synchronous and active-low: RESET==0 at posedge -> state IDLE, byte counter 0, MREAD=MWRITE=0, MADDRESS=0, MWRITEDATA=0, IREADDATA=0, DREADDATA=0.
- While RESET is low, IBUSYWAIT and DBUSYWAIT are forced to 0.
- States:
  - IDLE: no strobes.
  - D_MEM: data transfer in flight.
  - I_MEM: fetch byte transfer in flight, counter k in 0..IBYTES-1.
  - D_RESP: one-cycle data response.
  - I_RESP: one-cycle fetch response.
- IDLE transitions on the next posedge:
  - Data request pending (DREAD|DWRITE) -> D_MEM. Data has priority over fetch.
  - Otherwise, IREAD -> I_MEM with k=0.
  - If both are pending, data is served first and the fetch waits.
- Address and data latching: on entering D_MEM, latch DADDRESS and DWRITEDATA. If DWRITE, drive MWRITE; otherwise drive MREAD. If DREAD and DWRITE are both high, the write wins.
- D_MEM: hold the strobe, MADDRESS and MWRITEDATA until the completing edge. On that edge, capture MREADDATA into DREADDATA (reads only), drop strobes and go to D_RESP.
- I_MEM: MREAD high, MADDRESS = (latched IADDRESS + k) mod 2^ADDR_W (wraps).
  - On each completing edge, write MREADDATA into IREADDATA[8k+7:8k] (little-endian), then k <= k+1.
  - On the edge completing k=IBYTES-1: drop MREAD and go to I_RESP.
  - MREAD stays high between bytes; only the address advances.
- A fetch in progress is never preempted. A data request arriving mid-fetch waits until the fetch returns to IDLE.
- D_RESP/I_RESP -> IDLE unconditionally after one cycle. A request still high in the following IDLE cycle is treated as a new request.
- Busywait equations:
  - DBUSYWAIT = (DREAD|DWRITE) & state!=D_RESP.
  - IBUSYWAIT = IREAD & state!=I_RESP.
  - Both are combinational so a stall is raised in the same cycle the request appears.
- Requester drops its request mid-transfer: the memory transfer still completes, the state machine runs to RESP, and the result is discarded.
- Latency with zero-wait memory:
  - Data: request at cycle 0, strobe in cycle 1, busywait low in cycle 2.
  - Fetch: strobe in cycles 1-4, busywait low in cycle 5.
  - Each memory wait cycle adds one cycle.
- Reset asserted mid-transfer: strobes drop at that edge. The partially assembled IREADDATA is cleared, and no response cycle is issued.

Decomposition:
- Shared package: state encoding (IDLE, D_MEM, I_MEM, D_RESP, I_RESP) and constant IBYTES=4.
- One sub-module: ifetch_assembler. It holds the byte counter k, the address offset adder and the IREADDATA byte-lane writes, with inputs load/advance/clear.

Test Plan:
- Reset hold: RESET=0 for 2 cycles with IREAD=DREAD=1 -> all strobes 0, both busywaits 0, IREADDATA=0.
- Fetch: mem[0x10..0x13]=0x08,0x00,0x02,0x01, IREAD at 0x10, zero-wait memory -> MADDRESS 0x10,0x11,0x12,0x13 in cycles 1-4; IBUSYWAIT low in cycle 5 with IREADDATA=0x01020008.
- Store then load, with memory waiting 2 cycles per transfer:
  - DWRITE 0x5A to 0x20 -> DBUSYWAIT low in cycle 4.
  - A following DREAD at 0x20 -> DREADDATA=0x5A.
- Collision: IREAD and DREAD raised in the same cycle -> the data transfer is served first (D_RESP), then fetch strobes begin the cycle after IDLE; the fetch completes correctly.
- Wrap: IREAD at 0xFE -> byte addresses 0xFE,0xFF,0x00,0x01, assembled in order.
- Mid-fetch reset: RESET=0 during byte k=2 -> MREAD=0 at the next edge, no I_RESP, IREADDATA=0. A new fetch after release starts at k=0.
